// File: rtl/exu_bp_stall_ctl_pkg.sv
// Shared types for the EXU branch issue-stall sequencer.
//   bp_stall_state_t  : sequencer states (IDLE / WAIT / PAD)
//   BPS_MIN_STALL_DEF : default minimum stall per branch, in cycles
package exu_bp_stall_ctl_pkg;

  typedef enum logic [1:0] {
    BPS_IDLE = 2'd0,
    BPS_WAIT = 2'd1,
    BPS_PAD  = 2'd2
  } bp_stall_state_t;

  localparam int BPS_MIN_STALL_DEF = 4;

endpackage

// File: rtl/exu_bp_stall_ctl_if.sv
// Issue-control / branch-resolution bundle for exu_bp_stall_ctl.
//   master : decode issue control + primary ALU side (drives events, sees stall)
//   slave  : the stall sequencer
// Signals:
//   freeze, flush           pipeline freeze / lower flush
//   br_issue                branch issued to the primary ALU
//   res_valid, res_flush    branch resolved / resolution redirected
//   issue_stall, stall_done hold younger issue / normal release pulse
//   stat_branch/misp/pad    statistics counters (STAT_W bits each)
//   wdog_err                sticky watchdog error
interface exu_bp_stall_ctl_if #(
  parameter int STAT_W = 32
);

  logic              freeze;
  logic              flush;
  logic              br_issue;
  logic              res_valid;
  logic              res_flush;
  logic              issue_stall;
  logic              stall_done;
  logic [STAT_W-1:0] stat_branch;
  logic [STAT_W-1:0] stat_misp;
  logic [STAT_W-1:0] stat_pad;
  logic              wdog_err;

  modport master (
    output freeze, flush, br_issue, res_valid, res_flush,
    input  issue_stall, stall_done, stat_branch, stat_misp, stat_pad, wdog_err
  );

  modport slave (
    input  freeze, flush, br_issue, res_valid, res_flush,
    output issue_stall, stall_done, stat_branch, stat_misp, stat_pad, wdog_err
  );

endinterface

// File: rtl/exu_bp_stall_ctl.sv
// exu_bp_stall_ctl: issue-stall sequencer for the no-branch-prediction EXU build.
// Every branch issued to the primary ALU holds younger issue until it resolves,
// and the stall is padded to at least MIN_STALL cycles so branch cost does not
// depend on the outcome.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : exu_bp_stall_ctl_if.slave (issue/resolution events, stall, stats)
// Optional feature: define RV_BP_STALL_WDOG_EN to build the WAIT watchdog
// (WDOG_CYC cycles); otherwise wdog_err is tied to 0.
module exu_bp_stall_ctl
  import exu_bp_stall_ctl_pkg::*;
#(
  parameter int MIN_STALL = BPS_MIN_STALL_DEF,
  parameter int CNT_W     = 6,
  parameter int STAT_W    = 32,
  parameter int WDOG_CYC  = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  exu_bp_stall_ctl_if.slave        bus
);

  localparam logic [CNT_W:0]    MIN_EXT  = (CNT_W+1)'(MIN_STALL);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Reject out-of-range configurations at elaboration.
  if (MIN_STALL < 1 || MIN_STALL > (2**CNT_W) - 1 ||
      WDOG_CYC < 1 || WDOG_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("exu_bp_stall_ctl: MIN_STALL/WDOG_CYC out of range for CNT_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  bp_stall_state_t   state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    cnt_p1;
  logic              min_met;
  logic              pad_last;
  logic              br_accept;
  logic              wdog_hit;
  logic [STAT_W-1:0] stat_branch;
  logic [STAT_W-1:0] stat_misp;
  logic [STAT_W-1:0] stat_pad;

  // cnt+1 is evaluated one bit wider so a saturated counter still compares correctly.
  assign cnt_p1    = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign min_met   = (cnt_p1 >= MIN_EXT);
  assign pad_last  = (cnt_p1 == MIN_EXT);
  assign br_accept = (state == BPS_IDLE) && bus.br_issue && !bus.flush;

`ifdef RV_BP_STALL_WDOG_EN
  assign wdog_hit = (state == BPS_WAIT) && !bus.flush && !bus.res_valid &&
                    (cnt == CNT_W'(WDOG_CYC));
`else
  assign wdog_hit = 1'b0;
`endif

  // Stall decodes from the registered state only; release pulse is same-cycle
  // with the resolving event so issue resumes on the following cycle.
  assign bus.issue_stall = (state != BPS_IDLE);
  assign bus.stall_done  = !bus.freeze && !bus.flush &&
                           (((state == BPS_WAIT) && bus.res_valid && min_met) ||
                            ((state == BPS_PAD) && pad_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BPS_IDLE;
      cnt   <= '0;
    end else if (!bus.freeze) begin
      case (state)
        BPS_IDLE: begin
          if (br_accept) begin
            state <= BPS_WAIT;
            cnt   <= '0;
          end
        end
        BPS_WAIT: begin
          cnt <= sat_inc(cnt);
          if (bus.flush)          state <= BPS_IDLE;
          else if (bus.res_valid) state <= min_met ? BPS_IDLE : BPS_PAD;
          else if (wdog_hit)      state <= BPS_IDLE;
        end
        BPS_PAD: begin
          cnt <= sat_inc(cnt);
          if (bus.flush || pad_last) state <= BPS_IDLE;
        end
        default: state <= BPS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branch <= '0;
      stat_misp   <= '0;
      stat_pad    <= '0;
    end else if (!bus.freeze) begin
      if (br_accept)
        stat_branch <= stat_branch + STAT_ONE;
      if ((state == BPS_WAIT) && !bus.flush && bus.res_valid && bus.res_flush)
        stat_misp <= stat_misp + STAT_ONE;
      if (state == BPS_PAD)
        stat_pad <= stat_pad + STAT_ONE;
    end
  end

  assign bus.stat_branch = stat_branch;
  assign bus.stat_misp   = stat_misp;
  assign bus.stat_pad    = stat_pad;

`ifdef RV_BP_STALL_WDOG_EN
  logic wdog_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      wdog_err <= 1'b0;
    else if (!bus.freeze && wdog_hit) wdog_err <= 1'b1;
  end
  assign bus.wdog_err = wdog_err;
`else
  assign bus.wdog_err = 1'b0;
`endif

  // A new branch may only be issued while no stall is active.
  a_no_issue_in_stall: assert property (@(posedge clk) disable iff (rst)
    !(bus.br_issue && (state != BPS_IDLE)))
    else $error("exu_bp_stall_ctl: br_issue while stall active");

endmodule

// File: tb/tb_exu_bp_stall_ctl.sv
module tb_exu_bp_stall_ctl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  exu_bp_stall_ctl_if #(.STAT_W(32)) bus ();

  exu_bp_stall_ctl #(
    .MIN_STALL(4),
    .CNT_W(6),
    .STAT_W(32),
    .WDOG_CYC(63)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs applied just after the rising edge, outputs sampled on the falling edge.
  task automatic drive(input logic br, input logic rv, input logic rf,
                       input logic fl, input logic fz);
    @(posedge clk);
    #1;
    bus.br_issue  = br;
    bus.res_valid = rv;
    bus.res_flush = rf;
    bus.flush     = fl;
    bus.freeze    = fz;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_stall(input string tag, input logic st, input logic dn);
    chk({tag, "_stall"}, {31'd0, bus.issue_stall}, {31'd0, st});
    chk({tag, "_done"},  {31'd0, bus.stall_done},  {31'd0, dn});
  endtask

  task automatic chk_stats(input string tag, input int br, input int mp, input int pd);
    chk({tag, "_br"},  bus.stat_branch, br);
    chk({tag, "_mp"},  bus.stat_misp,   mp);
    chk({tag, "_pad"}, bus.stat_pad,    pd);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.br_issue = 1'b0; bus.res_valid = 1'b0; bus.res_flush = 1'b0;
    bus.flush = 1'b0; bus.freeze = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_stall("rst", 1'b0, 1'b0);
    chk_stats("rst", 0, 0, 0);
    chk("rst_wdog", {31'd0, bus.wdog_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // A: resolve at T+6 -> stall T1..T6, done at T6, no pad
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_stall("A_T0", 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk_stall("A_wait", 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("A_T6", 1'b1, 1'b1);
    idle();
    chk_stall("A_T7", 1'b0, 1'b0);
    chk_stats("A", 1, 0, 0);

    // B: resolve at T+1 with redirect -> 3 PAD cycles, done at T4
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_stall("B_T1", 1'b1, 1'b0);
    idle(); chk_stall("B_T2", 1'b1, 1'b0);
    idle(); chk_stall("B_T3", 1'b1, 1'b0);
    idle(); chk_stall("B_T4", 1'b1, 1'b1);
    idle(); chk_stall("B_T5", 1'b0, 1'b0);
    chk_stats("B", 2, 1, 3);

    // C: flush beats same-cycle resolution in WAIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_stall("C_T2", 1'b1, 1'b0);
    idle();
    chk_stall("C_T3", 1'b0, 1'b0);
    chk_stats("C", 3, 1, 3);

    // D: freeze 5 cycles inside PAD -> done moves from T4 to T9
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(); chk_stall("D_T2", 1'b1, 1'b0);
    for (int i = 3; i <= 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_stall("D_frz", 1'b1, 1'b0);
    end
    chk("D_frz_pad", bus.stat_pad, 32'd4);
    idle(); chk_stall("D_T8", 1'b1, 1'b0);
    idle(); chk_stall("D_T9", 1'b1, 1'b1);
    idle(); chk_stall("D_T10", 1'b0, 1'b0);
    chk_stats("D", 4, 1, 6);

    // E: branch discarded by same-cycle flush; F: branch ignored under freeze
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(); chk_stall("E", 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); chk_stall("F", 1'b0, 1'b0);
    chk("EF_br", bus.stat_branch, 32'd4);

    // G: flush during PAD -> IDLE without done; the PAD cycle still counts
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_stall("G_T2", 1'b1, 1'b0);
    idle(); chk_stall("G_T3", 1'b0, 1'b0);
    chk_stats("G", 5, 1, 7);

    // H1: resolve exactly at T+4 -> done at T4, no pad
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("H1_T4", 1'b1, 1'b1);
    idle(); chk_stall("H1_T5", 1'b0, 1'b0);
    chk_stats("H1", 6, 1, 7);

    // H2: resolve at T+3 -> one PAD cycle, done at T4
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("H2_T3", 1'b1, 1'b0);
    idle(); chk_stall("H2_T4", 1'b1, 1'b1);
    idle(); chk_stall("H2_T5", 1'b0, 1'b0);
    chk_stats("H2", 7, 1, 8);

    // I: no resolution for 64 cycles (watchdog case)
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (63) idle();
    idle();
    chk_stall("I_T64", 1'b1, 1'b0);
`ifdef RV_BP_STALL_WDOG_EN
    chk("I_T64_wdog", {31'd0, bus.wdog_err}, 32'd0);
    idle();
    chk_stall("I_T65", 1'b0, 1'b0);
    chk("I_wdog", {31'd0, bus.wdog_err}, 32'd1);
    repeat (3) idle();
    chk("I_wdog_sticky", {31'd0, bus.wdog_err}, 32'd1);
`else
    idle();
    chk_stall("I_T65", 1'b1, 1'b0);
    chk("I_wdog", {31'd0, bus.wdog_err}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("I_T66", 1'b1, 1'b1);
    idle(); chk_stall("I_T67", 1'b0, 1'b0);
`endif
    chk_stats("I", 8, 1, 8);

    // J: asynchronous reset in the middle of WAIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk_stall("J_T1", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_stall("J_rst", 1'b0, 1'b0);
    chk_stats("J_rst", 0, 0, 0);
    chk("J_wdog", {31'd0, bus.wdog_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    chk_stall("J_after", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
